// File: rtl/chaos_euler_gen.sv
// Fixed-point Euler integrator for the Lorenz, Chen and Lu chaotic systems.
// Define CHAOS_SAT_EN to saturate state updates; by default they wrap modulo 2^Width.
module chaos_euler_gen #(
  parameter int unsigned Width   = 32,
  parameter int unsigned Frac    = 21,
  parameter int unsigned DtShift = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [1:0]              mode_i,
  input  logic [31:0]             iter_i,
  output logic signed [Width-1:0] xn_o,
  output logic signed [Width-1:0] yn_o,
  output logic signed [Width-1:0] zn_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, UPDT, DONE} state_t;
  typedef logic signed [Width-1:0] word_t;

  localparam longint One = longint'(1) <<< Frac;

  // Coefficients in Q format; only Lorenz b=8/3 is non-integer (rounded to nearest)
  localparam word_t QOne   = Width'(One);
  localparam word_t LorA   = Width'(10 * One);
  localparam word_t LorB   = Width'((16 * One + 3) / 6);
  localparam word_t LorC   = Width'(28 * One);
  localparam word_t ChenA  = Width'(35 * One);
  localparam word_t ChenB  = Width'(3 * One);
  localparam word_t ChenC  = Width'(28 * One);
  localparam word_t ChenCa = Width'(-7 * One);
  localparam word_t LuA    = Width'(36 * One);
  localparam word_t LuB    = Width'(3 * One);
  localparam word_t LuC    = Width'(20 * One);

  state_t      state;
  logic [1:0]  mode_q;
  logic [31:0] iter_q;
  logic [31:0] cnt;
  logic [31:0] cnt_inc;
  word_t       dx, dy, dz;
  word_t       dx_c, dy_c, dz_c;
  word_t       coef_a, coef_b, coef_c;
  word_t       xz, xy, cy;

  // Q multiply: full-width product, arithmetic shift by Frac, truncate to Width
  function automatic word_t qmul(input word_t p, input word_t q);
    logic signed [2*Width-1:0] prod;
    prod = (2*Width)'(p) * (2*Width)'(q);
    return Width'(prod >>> Frac);
  endfunction

  function automatic word_t step(input word_t s, input word_t ds);
    word_t inc;
`ifdef CHAOS_SAT_EN
    logic signed [Width:0] sum;
`endif
    inc = ds >>> DtShift;
`ifdef CHAOS_SAT_EN
    sum = (Width+1)'(s) + (Width+1)'(inc);
    if (sum[Width] != sum[Width-1])
      return sum[Width] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    return sum[Width-1:0];
`else
    return s + inc;
`endif
  endfunction

  assign cnt_inc = cnt + 32'd1;

  // Derivatives of the latched system at the current state
  always_comb begin
    coef_a = ChenA;
    coef_b = ChenB;
    coef_c = ChenC;
    case (mode_q)
      2'd0: begin coef_a = LorA; coef_b = LorB; coef_c = LorC; end
      2'd2: begin coef_a = LuA;  coef_b = LuB;  coef_c = LuC;  end
      default: ;
    endcase
    xz   = qmul(xn_o, zn_o);
    xy   = qmul(xn_o, yn_o);
    cy   = qmul(coef_c, yn_o);
    dx_c = qmul(coef_a, yn_o - xn_o);
    dz_c = xy - qmul(coef_b, zn_o);
    case (mode_q)
      2'd0:    dy_c = qmul(xn_o, coef_c - zn_o) - yn_o;
      2'd2:    dy_c = cy - xz;
      default: dy_c = qmul(ChenCa, xn_o) - xz + cy;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      xn_o    <= '0;
      yn_o    <= '0;
      zn_o    <= '0;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      cnt     <= '0;
      mode_q  <= '0;
      iter_q  <= '0;
      dx      <= '0;
      dy      <= '0;
      dz      <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state  <= LOAD;
          busy_o <= 1'b1;
        end
        LOAD: begin
          xn_o    <= QOne;
          yn_o    <= QOne;
          zn_o    <= QOne;
          mode_q  <= mode_i;
          iter_q  <= iter_i;
          cnt     <= '0;
          valid_o <= 1'b1;
          state   <= CALC;
        end
        CALC: begin
          dx    <= dx_c;
          dy    <= dy_c;
          dz    <= dz_c;
          state <= UPDT;
        end
        UPDT: begin
          xn_o    <= step(xn_o, dx);
          yn_o    <= step(yn_o, dy);
          zn_o    <= step(zn_o, dz);
          cnt     <= cnt_inc;
          valid_o <= 1'b1;
          if (iter_q != 32'd0 && cnt_inc == iter_q) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (!start_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            state <= CALC;
          end
        end
        DONE: if (!start_i) begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chaos_euler_gen.sv
// Bench for chaos_euler_gen: directed and randomized runs against a plain-arithmetic Euler model.
module tb_chaos_euler_gen;

  localparam int DT = 10;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start2 = 1'b0;
  logic [1:0]  mode_in = 2'd0, mode2 = 2'd0;
  logic [31:0] iter_in = 32'd0, iter2 = 32'd0;
  logic [31:0] xn, yn, zn, xn2, yn2, zn2;
  logic        valid, busy, done, valid2, busy2, done2;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chaos_euler_gen dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode_in), .iter_i(iter_in),
    .xn_o(xn), .yn_o(yn), .zn_o(zn), .valid_o(valid), .busy_o(busy), .done_o(done)
  );

  chaos_euler_gen #(.Width(32), .Frac(29), .DtShift(10)) dut_ovf (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .mode_i(mode2), .iter_i(iter2),
    .xn_o(xn2), .yn_o(yn2), .zn_o(zn2), .valid_o(valid2), .busy_o(busy2), .done_o(done2)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Q-format multiply of the reference model: exact product, floor-shift, keep 32 bits
  function automatic int qm(input int p, input int q, input int f);
    longint pr;
    pr = longint'(p) * longint'(q);
    return int'(pr >>> f);
  endfunction

  function automatic int upd(input int s, input int d);
    longint n;
    n = longint'(s) + longint'(d >>> DT);
`ifdef CHAOS_SAT_EN
    if (n > MAXV) return int'(MAXV);
    if (n < MINV) return int'(MINV);
`endif
    return int'(n);
  endfunction

  task automatic model_step(input int m, input int f, inout int x, inout int y, inout int z);
    longint one;
    int a, b, c, dx, dy, dz;
    one = longint'(1) <<< f;
    if (m == 0) begin
      a = int'(10 * one); c = int'(28 * one);
      b = $rtoi(8.0 / 3.0 * real'(one) + 0.5);
    end else if (m == 2) begin
      a = int'(36 * one); b = int'(3 * one); c = int'(20 * one);
    end else begin
      a = int'(35 * one); b = int'(3 * one); c = int'(28 * one);
    end
    dx = qm(a, y - x, f);
    if (m == 0)      dy = qm(x, c - z, f) - y;
    else if (m == 2) dy = qm(c, y, f) - qm(x, z, f);
    else             dy = qm(c - a, x, f) - qm(x, z, f) + qm(c, y, f);
    dz = qm(x, y, f) - qm(b, z, f);
    x = upd(x, dx);
    y = upd(y, dy);
    z = upd(z, dz);
  endtask

  task automatic wait_valid(input bit which, output bit ok, output int gap);
    ok = 1'b0;
    gap = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if ((which ? valid2 : valid) === 1'b1) begin
        ok = 1'b1;
        gap = i;
        break;
      end
    end
    if (!ok) check("valid_timeout", which ? valid2 : valid, 1'b1);
  endtask

  // One run on the default instance; stop_at>0 drops start at that pulse (during CALC)
  task automatic run(input int m, input int it, input bit perturb, input int stop_at);
    int x, y, z, gap, last;
    bit ok;
    x = 32'h00200000; y = x; z = x;
    mode_in = 2'(m);
    iter_in = it;
    start = 1'b1;
    last = (stop_at > 0) ? stop_at + 1 : it;
    for (int k = 0; k <= last; k++) begin
      wait_valid(1'b0, ok, gap);
      if (!ok) return;
      if (k > 0) model_step(m, 21, x, y, z);
      check("sample", {xn, yn, zn}, {x, y, z});
      check("valid_gap", gap, 2);
      if (stop_at == 0) check("done_with_last", done, k == it);
      if (perturb && k == 0) begin
        mode_in = 2'($urandom);
        iter_in = $urandom_range(1, 3);
      end
      if (stop_at > 0 && k == stop_at) start = 1'b0;
    end
    if (stop_at > 0) begin
      check("busy_after_stop", busy, 1'b0);
      repeat (3) tick();
      check("held_after_stop", {xn, yn, zn}, {x, y, z});
      check("idle_flags", {valid, busy, done}, 3'b000);
    end else begin
      repeat (3) tick();
      check("done_hold", {valid, busy, done}, 3'b001);
      check("held_in_done", {xn, yn, zn}, {x, y, z});
      start = 1'b0;
      tick(); tick();
      check("done_release", {valid, busy, done}, 3'b000);
    end
  endtask

  initial begin
    int x, y, z, gap;
    bit ok;

    repeat (2) tick();
    check("reset_outputs", {xn, yn, zn}, 96'd0);
    check("reset_flags", {valid, busy, done}, 3'b000);
    rst = 1'b0;
    tick();
    check("idle_after_reset", {valid, busy, done}, 3'b000);

    // Chen first step against hand-computed constants
    mode_in = 2'd1; iter_in = 32'd0; start = 1'b1;
    tick();
    check("busy_in_load", busy, 1'b1);
    wait_valid(1'b0, ok, gap);
    check("chen_init", {xn, yn, zn}, {32'h00200000, 32'h00200000, 32'h00200000});
    wait_valid(1'b0, ok, gap);
    check("chen_step1", {xn, yn, zn}, {32'h00200000, 32'h0020A000, 32'h001FF000});
    check("chen_gap", gap, 2);
    start = 1'b0;
    wait_valid(1'b0, ok, gap);
    tick();
    check("chen_stopped", {valid, busy, done}, 3'b000);

    // Golden runs with mode/iter perturbed after LOAD
    for (int m = 0; m < 3; m++) run(m, 1000, 1'b1, 0);
    run(0, 5, 1'b0, 0);
    run($urandom_range(0, 3), $urandom_range(1, 20), 1'b1, 0);
    run($urandom_range(0, 3), 0, 1'b1, $urandom_range(1, 10));

    // Reset mid-run
    mode_in = 2'd0; iter_in = 32'd0; start = 1'b1;
    repeat (3) wait_valid(1'b0, ok, gap);
    tick();
    rst = 1'b1;
    tick(); tick();
    check("midrun_reset_outputs", {xn, yn, zn}, 96'd0);
    check("midrun_reset_flags", {valid, busy, done}, 3'b000);
    rst = 1'b0; start = 1'b0;
    repeat (2) tick();
    check("idle_after_midrun_reset", {valid, busy, done, xn}, 35'd0);

    // Q3.29 Lorenz free-run: overflow behaviour (wrap or clamp) against the model
    x = 32'h20000000; y = x; z = x;
    start2 = 1'b1;
    for (int k = 0; k <= 300; k++) begin
      wait_valid(1'b1, ok, gap);
      if (!ok) break;
      if (k > 0) model_step(0, 29, x, y, z);
      check("ovf_sample", {xn2, yn2, zn2}, {x, y, z});
    end
    start2 = 1'b0;
    repeat (4) tick();
    check("ovf_idle", {valid2, busy2, done2}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/chaos_euler_gen.md
CHAOS_EULER_GEN -- requirements
Module: chaos_euler_gen

Interface
REQ-001 SHALL have parameter Width, default 32, data word width in bits.
REQ-002 SHALL have parameter Frac, default 21, fractional bits of the signed Q format; Width-Frac >= 2.
REQ-003 SHALL have parameter DtShift, default 10, Euler step h = 2^-DtShift.
REQ-004 SHALL have port clk_i  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port start_i  input  1  run request; level-sensitive.
REQ-007 SHALL have port mode_i  input  2  system select: 0 Lorenz, 1 Chen, 2 Lu, 3 treated as Chen.
REQ-008 SHALL have port iter_i  input  32  number of Euler steps to run; 0 means free-run.
REQ-009 SHALL have ports xn_o, yn_o, zn_o  output  Width each  state x, y, z, signed Q(Width-Frac).Frac.
REQ-010 SHALL have port valid_o  output  1  one-cycle pulse when a new sample is on xn_o/yn_o/zn_o.
REQ-011 SHALL have port busy_o  output  1  high in LOAD, CALC and UPDT.
REQ-012 SHALL have port done_o  output  1  high while in DONE.

Function
REQ-013 SHALL implement the FSM states IDLE, LOAD, CALC, UPDT and DONE.
REQ-014 IDLE SHALL hold the outputs and go to LOAD when start_i=1.
REQ-015 LOAD SHALL set x=y=z=1.0, latch mode_i and iter_i, clear the step counter, then go to CALC.
REQ-016 CALC SHALL register the derivatives, using full 2*Width-bit products arithmetic-shifted right by Frac and truncated to Width.
REQ-017 Derivatives: Lorenz dx=a(y-x), dy=x(c-z)-y, dz=xy-bz with a=10, b=8/3, c=28; Chen dx=a(y-x), dy=(c-a)x-xz+cy, dz=xy-bz with a=35, b=3, c=28; Lu dx=a(y-x), dy=-xz+cy, dz=xy-bz with a=36, b=3, c=20.
REQ-018 Non-integer coefficients SHALL be Q constants rounded to nearest at elaboration; integer coefficients SHALL be exact.
REQ-019 UPDT SHALL update s <= s + (ds >>> DtShift) for each state s and increment the counter.
REQ-020 After UPDT, go to DONE if iter_i!=0 and counter==iter_i; else go to IDLE if start_i=0; else go to CALC.
REQ-021 valid_o SHALL be registered, asserted in the cycle after LOAD and after each UPDT, giving one sample every 2 cycles while running.
REQ-022 DONE SHALL hold the outputs and return to IDLE only when start_i=0.
REQ-023 mode_i and iter_i changes after LOAD SHALL be ignored until the next LOAD.
REQ-024 The final valid_o pulse and done_o SHALL first assert in the same cycle.

Reset
REQ-025 rst_i=1 SHALL, at the next edge, set the FSM to IDLE and xn_o, yn_o, zn_o, valid_o, busy_o, done_o and the counter to 0.
REQ-026 Reset SHALL have priority over every FSM transition, including mid-step.

Configuration
REQ-027 With macro CHAOS_SAT_EN defined, state updates SHALL saturate to the most positive value (0x7FF...F) or most negative value (0x800...0).
REQ-028 Without CHAOS_SAT_EN, state updates SHALL wrap modulo 2^Width.

Verification
REQ-029 Reset test: rst_i high for 2 cycles mid-run -> all outputs 0 next cycle, FSM in IDLE.
REQ-030 Chen first step, defaults: start_i=1, mode_i=1, iter_i=0 -> first valid sample is 0x00200000/0x00200000/0x00200000; second is x=0x00200000, y=0x0020A000, z=0x001FF000; valid_o every 2 cycles.
REQ-031 Golden model: Lorenz, Chen and Lu each run 1000 steps -> bit-exact against a fixed-point software model.
REQ-032 Bounded run: iter_i=5 -> exactly 6 valid_o pulses (initial condition plus 5 steps); done_o rises with the 6th; done_o stays high until start_i=0.
REQ-033 Stop: start_i dropped during CALC -> the current step completes with one valid_o; then IDLE, busy_o=0, outputs held.
REQ-034 Overflow: Width=32, Frac=29, Lorenz, free-run -> with CHAOS_SAT_EN outputs clamp at 0x7FFFFFFF/0x80000000; without it they wrap.
